pit_counter: RTL and testbench
==============================

# pit_counter

One 16-bit down-counter channel of the XT programmable interval timer, fed by the 1.193182 MHz tick from the clock-enable generator. It holds the CPU-programmed count, counts on tick cycles only, and drives the channel output: the IRQ0 source for channel 0 and the speaker tone for channel 2. The register and port decode wrapper instantiates three copies and routes CPU bus strobes to each one.

## Interface
- INIT_MODE, 0: operating mode loaded at reset (0, 2 or 3).
- iClk  in  1  system clock (25 MHz).
- iRst  in  1  asynchronous, active-high reset.
- iClkEn  in  1  counting tick, one iClk wide, from the clock-enable generator.
- iGate  in  1  gate input, sampled only on iClkEn cycles.
- iCtrlWr  in  1  single-cycle strobe: control word for this channel on iData.
- iWr  in  1  single-cycle strobe: count byte on iData.
- iRd  in  1  single-cycle strobe: CPU reads oData this cycle.
- iData  in  8  CPU write data.
- oData  out  8  read data, combinational from current state.
- oOut  out  1  channel output, registered.

## Operation
- **Control word fields:** iData[5:4] RW, iData[3:1] M. BCD bit [0] is ignored; counting is binary only.
  - RW=00: latch command. Copy the live count into the output latch unless a latch is already held.
  - RW≠00: store RW and mode. Both byte flip-flops return to LSB, any latch is dropped, and the counter goes idle until a new count completes.
    - Mode decode: M=x10 → mode 2, M=x11 → mode 3, anything else → mode 0.
    - oOut on mode write: low for mode 0, high for modes 2 and 3.
- **Count write, by RW:**
  - 01: LSB only, MSB cleared.
  - 10: MSB only, LSB cleared.
  - 11: LSB then MSB. The write flip-flop toggles; the count is complete after the MSB.
- **Count value:** the completed count N is stored. N=0 means 65536. N=1 in modes 2 and 3 is treated as 2.
- **Read, by RW:** the source is the latch if one is held, otherwise the live counter. The read flip-flop alternates LSB/MSB under RW=11. The latch is released once all of its bytes have been read.
- **Mode 0 (interrupt on terminal count):**
  - Count completion drives oOut low and arms a load.
  - Decrement on each tick while iGate=1.
  - oOut goes high when the count goes 1→0 and stays high. The counter wraps 0→FFFF and keeps counting.
  - A new count restarts the sequence.
- **Mode 2 (rate generator):**
  - oOut goes low on the 2→1 transition and stays low for exactly one tick.
  - On the next tick, reload N and drive oOut high.
  - iGate=0 freezes the counter and forces oOut high. An iGate rising edge reloads N on the next tick.
  - A count written mid-period takes effect at the next reload.
- **Mode 3 (square wave):**
  - The counter decrements by 2 per tick. On reaching 0, oOut toggles and the counter reloads.
  - Even N: reload N.
  - Odd N: reload N+1 when entering the high phase and N−1 when entering the low phase. This gives ceil(N/2) ticks high and floor(N/2) ticks low.
  - Gate behaviour and mid-period writes are the same as mode 2.

## Timing
- **Reset values:** oOut=0, counter=0, N=0, mode=INIT_MODE, RW=11, idle (no load armed), no latch held, both flip-flops at LSB. Reset acts immediately mid-operation.
- **Load:** happens on the first iClkEn strictly after the cycle that completed the count. A write coincident with iClkEn does not load on that same tick. The load tick performs no decrement.
- **Mode 0:** oOut rises on the N-th tick after the load tick.
- **Mode 2:** period is N ticks. The low pulse is one tick period wide, starting on the tick where count=1.
- **Simultaneous strobes:**
  - iCtrlWr together with iWr: the control write wins and the data byte is dropped.
  - iRd together with the latch command: the read returns the pre-latch source, and the latch is captured.
- **Strobe rate:** every strobe is honoured on every iClk cycle. Nothing is pipelined beyond the registered oOut.
- **Tick rate:** iClkEn is never asserted on consecutive cycles; no dependency exists on that.

## Test plan
- Reset, control 0x36 (RW=11, mode 3), write 0x00 then 0x00 → oOut toggles every 32768 ticks, period 65536 ticks.
- Control 0x30 (mode 0), write 0x05 then 0x00, iGate=1 → oOut low, then high on the 5th tick after the load tick, and stays high through the counter wrap.
- Control 0x14 (RW=01, mode 2), write 0x04 → oOut low for one tick every 4 ticks. Drop iGate mid-count → oOut high, counter frozen. Raise iGate → reload 4 on the next tick.
- Mode 3 with N=5 → 3 ticks high, 2 ticks low, repeating.
- Mode 2 running with count 0x1234: issue latch command 0x00, wait 10 ticks, read twice → 0x34 then 0x12 (the latched value, not the live count). A third read returns the live LSB.
- Assert iCtrlWr and iWr in the same cycle → count unchanged. Assert iRst mid-count → oOut=0 immediately and the counter idles until reprogrammed.

Source files
------------

// File: rtl/pit_counter.sv
// rtl/pit_counter.sv - one 16-bit down-counter channel of the XT interval timer
// Binary counting only; supports modes 0, 2 and 3 with count latch and byte-sequenced access.
module pit_counter #(
  parameter int INIT_MODE = 0
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iClkEn,
  input  logic       iGate,
  input  logic       iCtrlWr,
  input  logic       iWr,
  input  logic       iRd,
  input  logic [7:0] iData,
  output logic [7:0] oData,
  output logic       oOut
);

  typedef enum logic [1:0] {
    MODE_0 = 2'd0,
    MODE_2 = 2'd2,
    MODE_3 = 2'd3
  } mode_e;

  localparam mode_e RESET_MODE = (INIT_MODE == 2) ? MODE_2 :
                                 (INIT_MODE == 3) ? MODE_3 : MODE_0;

  mode_e       mode_q, mode_d;
  logic [1:0]  rw_q, rw_d;
  logic [15:0] count_q, count_d;
  logic [15:0] n_q, n_d;
  logic [7:0]  lsb_stage_q, lsb_stage_d;
  logic        wr_msb_q, wr_msb_d;
  logic        rd_msb_q, rd_msb_d;
  logic [15:0] latch_q, latch_d;
  logic        latched_q, latched_d;
  logic        armed_q, armed_d;
  logic        running_q, running_d;
  logic        out_q, out_d;

  logic [15:0] n_eff;
  logic [15:0] reload_hi;
  logic [15:0] reload_lo;
  logic [15:0] rd_src;
  logic        rd_hi;
  logic [15:0] new_n;
  logic        complete;
  mode_e       ctrl_mode;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      mode_q      <= RESET_MODE;
      rw_q        <= 2'b11;
      count_q     <= 16'd0;
      n_q         <= 16'd0;
      lsb_stage_q <= 8'd0;
      wr_msb_q    <= 1'b0;
      rd_msb_q    <= 1'b0;
      latch_q     <= 16'd0;
      latched_q   <= 1'b0;
      armed_q     <= 1'b0;
      running_q   <= 1'b0;
      out_q       <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      rw_q        <= rw_d;
      count_q     <= count_d;
      n_q         <= n_d;
      lsb_stage_q <= lsb_stage_d;
      wr_msb_q    <= wr_msb_d;
      rd_msb_q    <= rd_msb_d;
      latch_q     <= latch_d;
      latched_q   <= latched_d;
      armed_q     <= armed_d;
      running_q   <= running_d;
      out_q       <= out_d;
    end
  end

  // Read source and byte select are purely from current state.
  always_comb begin
    rd_src = latched_q ? latch_q : count_q;
    rd_hi  = (rw_q == 2'b10) || ((rw_q == 2'b11) && rd_msb_q);
    oData  = rd_hi ? rd_src[15:8] : rd_src[7:0];
  end

  always_comb begin
    mode_d      = mode_q;
    rw_d        = rw_q;
    count_d     = count_q;
    n_d         = n_q;
    lsb_stage_d = lsb_stage_q;
    wr_msb_d    = wr_msb_q;
    rd_msb_d    = rd_msb_q;
    latch_d     = latch_q;
    latched_d   = latched_q;
    armed_d     = armed_q;
    running_d   = running_q;
    out_d       = out_q;
    new_n       = n_q;
    complete    = 1'b0;
    ctrl_mode   = MODE_0;

    // A count of 1 cannot produce a low pulse or two half-periods, so it runs as 2.
    n_eff     = ((mode_q != MODE_0) && (n_q == 16'd1)) ? 16'd2 : n_q;
    reload_hi = n_eff[0] ? n_eff + 16'd1 : n_eff;
    reload_lo = n_eff[0] ? n_eff - 16'd1 : n_eff;

    if (iClkEn) begin
      if (armed_q) begin
        if (mode_q == MODE_0) begin
          count_d   = n_eff;
          armed_d   = 1'b0;
          running_d = 1'b1;
        end else if (iGate) begin
          count_d   = (mode_q == MODE_3) ? reload_hi : n_eff;
          out_d     = 1'b1;
          armed_d   = 1'b0;
          running_d = 1'b1;
        end else begin
          out_d = 1'b1;
        end
      end else if (running_q) begin
        case (mode_q)
          MODE_0: begin
            if (iGate) begin
              count_d = count_q - 16'd1;
              if (count_q == 16'd1) out_d = 1'b1;
            end
          end
          MODE_2: begin
            if (!iGate) begin
              out_d   = 1'b1;
              armed_d = 1'b1;
            end else if (count_q == 16'd2) begin
              count_d = 16'd1;
              out_d   = 1'b0;
            end else if (count_q == 16'd1) begin
              count_d = n_eff;
              out_d   = 1'b1;
            end else begin
              count_d = count_q - 16'd1;
            end
          end
          default: begin
            if (!iGate) begin
              out_d   = 1'b1;
              armed_d = 1'b1;
            end else if (count_q == 16'd2) begin
              out_d   = ~out_q;
              count_d = out_q ? reload_lo : reload_hi;
            end else begin
              count_d = count_q - 16'd2;
            end
          end
        endcase
      end
    end

    if (iRd) begin
      if (rw_q == 2'b11) rd_msb_d = ~rd_msb_q;
      if (latched_q && ((rw_q != 2'b11) || rd_msb_q)) latched_d = 1'b0;
    end

    if (iCtrlWr) begin
      if (iData[5:4] == 2'b00) begin
        if (!latched_q) begin
          latch_d   = count_q;
          latched_d = 1'b1;
        end
      end else begin
        case (iData[2:1])
          2'b10:   ctrl_mode = MODE_2;
          2'b11:   ctrl_mode = MODE_3;
          default: ctrl_mode = MODE_0;
        endcase
        mode_d    = ctrl_mode;
        rw_d      = iData[5:4];
        wr_msb_d  = 1'b0;
        rd_msb_d  = 1'b0;
        latched_d = 1'b0;
        armed_d   = 1'b0;
        running_d = 1'b0;
        out_d     = (ctrl_mode != MODE_0);
      end
    end else if (iWr) begin
      case (rw_q)
        2'b01: begin
          new_n    = {8'h00, iData};
          complete = 1'b1;
        end
        2'b10: begin
          new_n    = {iData, 8'h00};
          complete = 1'b1;
        end
        2'b11: begin
          if (!wr_msb_q) begin
            lsb_stage_d = iData;
            wr_msb_d    = 1'b1;
          end else begin
            new_n    = {iData, lsb_stage_q};
            wr_msb_d = 1'b0;
            complete = 1'b1;
          end
        end
        default: ;
      endcase
      // Periodic modes already running pick up a new count at their next reload.
      if (complete) begin
        n_d = new_n;
        if ((mode_q == MODE_0) || !running_q) begin
          armed_d   = 1'b1;
          running_d = 1'b0;
          if (mode_q == MODE_0) out_d = 1'b0;
        end
      end
    end
  end

  assign oOut = out_q;

endmodule

// File: tb/tb_pit_counter.sv
// tb/tb_pit_counter.sv - scoreboard bench for one interval-timer channel
module tb_pit_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       clk_en;
  logic       gate;
  logic       ctrl_wr;
  logic       wr;
  logic       rd;
  logic [7:0] data;
  logic [7:0] rdata;
  logic       out;

  always #5 clk = ~clk;

  pit_counter #(.INIT_MODE(0)) dut (
    .iClk   (clk),
    .iRst   (rst),
    .iClkEn (clk_en),
    .iGate  (gate),
    .iCtrlWr(ctrl_wr),
    .iWr    (wr),
    .iRd    (rd),
    .iData  (data),
    .oData  (rdata),
    .oOut   (out)
  );

  typedef struct {
    string       tag;
    logic [15:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] want);
    checks++;
    if (obs !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, want);
    end
  endtask

  task automatic sb_push(input string tag, input logic [15:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input logic [15:0] obs);
    exp_t e;
    if (sb_q.size() == 0) begin
      check("sb_empty", 16'(sb_q.size()), 16'd1);
    end else begin
      e = sb_q.pop_front();
      check(e.tag, obs, e.val);
    end
  endtask

  task automatic tick(input logic g, input string tag, input logic want);
    sb_push(tag, {15'd0, want});
    @(negedge clk);
    clk_en = 1'b1;
    gate   = g;
    @(negedge clk);
    clk_en = 1'b0;
    sb_pop({15'd0, out});
  endtask

  task automatic tick_nc(input logic g, output logic o);
    @(negedge clk);
    clk_en = 1'b1;
    gate   = g;
    @(negedge clk);
    clk_en = 1'b0;
    o = out;
  endtask

  task automatic ctrl(input logic [7:0] d);
    @(negedge clk);
    ctrl_wr = 1'b1;
    data    = d;
    @(negedge clk);
    ctrl_wr = 1'b0;
  endtask

  task automatic wr_byte(input logic [7:0] d);
    @(negedge clk);
    wr   = 1'b1;
    data = d;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic rd_byte(input string tag, input logic [7:0] want);
    sb_push(tag, {8'h00, want});
    @(negedge clk);
    rd = 1'b1;
    #1;
    sb_pop({8'h00, rdata});
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic out_now(input string tag, input logic want);
    sb_push(tag, {15'd0, want});
    #1;
    sb_pop({15'd0, out});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    logic o;

    rst = 1'b1; clk_en = 1'b0; gate = 1'b1; ctrl_wr = 1'b0; wr = 1'b0; rd = 1'b0; data = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    out_now("rst_out", 1'b0);
    rd_byte("rst_lsb", 8'h00);
    rd_byte("rst_msb", 8'h00);

    // Mode 3, N=65536
    ctrl(8'h36);
    out_now("m3_ctrl_out", 1'b1);
    wr_byte(8'h00);
    wr_byte(8'h00);
    tick(1'b1, "m3_load", 1'b1);
    tick(1'b1, "m3_t1", 1'b1);
    rd_byte("m3_rd_lsb", 8'hFE);
    rd_byte("m3_rd_msb", 8'hFF);
    sb_push("m3_half_period", 16'd32768);
    n = 1;
    o = 1'b1;
    while (n < 33000 && o) begin
      tick_nc(1'b1, o);
      n++;
    end
    sb_pop(16'(n));
    tick(1'b1, "m3_low_hold", 1'b0);

    // Mode 0, N=5
    ctrl(8'h30);
    out_now("m0_ctrl_out", 1'b0);
    wr_byte(8'h05);
    wr_byte(8'h00);
    tick(1'b1, "m0_load", 1'b0);
    for (int i = 1; i <= 7; i++) tick(1'b1, $sformatf("m0_t%0d", i), (i >= 5));
    rd_byte("m0_wrap_lsb", 8'hFE);
    rd_byte("m0_wrap_msb", 8'hFF);

    // Mode 2, LSB only, N=4, with gate
    ctrl(8'h14);
    out_now("m2_ctrl_out", 1'b1);
    wr_byte(8'h04);
    tick(1'b1, "m2_load", 1'b1);
    for (int i = 1; i <= 10; i++) tick(1'b1, $sformatf("m2_t%0d", i), ((i % 4) != 3));
    tick(1'b0, "m2_gate_lo1", 1'b1);
    rd_byte("m2_frozen1", 8'h02);
    tick(1'b0, "m2_gate_lo2", 1'b1);
    rd_byte("m2_frozen2", 8'h02);
    tick(1'b1, "m2_gate_hi", 1'b1);
    rd_byte("m2_reload", 8'h04);
    for (int i = 1; i <= 4; i++) tick(1'b1, $sformatf("m2_g%0d", i), ((i % 4) != 3));

    // Mode 3, N=5: 3 high, 2 low
    ctrl(8'h16);
    wr_byte(8'h05);
    tick(1'b1, "m3o_load", 1'b1);
    for (int i = 1; i <= 10; i++) tick(1'b1, $sformatf("m3o_t%0d", i), ((i % 5) < 3));

    // Mode 2 with 0x1234, latch behaviour
    ctrl(8'h34);
    wr_byte(8'h34);
    wr_byte(8'h12);
    tick(1'b1, "lat_load", 1'b1);
    ctrl(8'h00);
    for (int i = 0; i < 10; i++) tick(1'b1, "lat_run", 1'b1);
    rd_byte("lat_lsb", 8'h34);
    rd_byte("lat_msb", 8'h12);
    rd_byte("live_lsb", 8'h2A);
    tick(1'b1, "lat_run2", 1'b1);
    tick(1'b1, "lat_run2", 1'b1);
    sb_push("rd_with_latch", 16'h0012);
    @(negedge clk);
    rd = 1'b1; ctrl_wr = 1'b1; data = 8'h00;
    #1;
    sb_pop({8'h00, rdata});
    @(negedge clk);
    rd = 1'b0; ctrl_wr = 1'b0;
    for (int i = 0; i < 3; i++) tick(1'b1, "lat_run3", 1'b1);
    rd_byte("lat2_lsb", 8'h28);
    rd_byte("lat2_msb", 8'h12);
    rd_byte("live2_lsb", 8'h25);

    // Control and data strobes together: control wins, byte dropped
    @(negedge clk);
    ctrl_wr = 1'b1; wr = 1'b1; data = 8'h14;
    @(negedge clk);
    ctrl_wr = 1'b0; wr = 1'b0;
    out_now("both_out", 1'b1);
    for (int i = 0; i < 3; i++) tick(1'b1, "both_idle", 1'b1);
    rd_byte("both_count", 8'h25);
    wr_byte(8'h07);
    tick(1'b1, "resume_load", 1'b1);
    rd_byte("resume_n", 8'h07);
    tick(1'b1, "resume_t1", 1'b1);
    rd_byte("resume_dec", 8'h06);

    // Asynchronous reset mid-count
    tick(1'b1, "pre_rst", 1'b1);
    @(negedge clk);
    rst = 1'b1;
    out_now("rst_async", 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) tick(1'b1, "rst_idle", 1'b0);
    rd_byte("rst_idle_lsb", 8'h00);
    rd_byte("rst_idle_msb", 8'h00);
    wr_byte(8'h03);
    wr_byte(8'h00);
    tick(1'b1, "rst_m0_load", 1'b0);
    for (int i = 1; i <= 3; i++) tick(1'b1, $sformatf("rst_m0_t%0d", i), (i == 3));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
